// File: rtl/ascon_inv_sbox_layer_if.sv
// Handshake bundle for the inverse ASCON substitution layer: one 320-bit
// state in on a valid/ready pair, one 320-bit result out on a valid/ready pair.
interface ascon_inv_sbox_layer_if;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [319:0] state_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [319:0] state_o;

  // Block side: consumes the input state and produces the result.
  modport slave (
    input  in_valid_i,
    input  state_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output state_o
  );

  // Producer/consumer side.
  modport master (
    output in_valid_i,
    output state_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  state_o
  );
endinterface

// File: rtl/ascon_inv_sbox_layer.sv
// Iterative inverse of the ASCON 5-bit S-box layer over the 320-bit state.
// A state is captured in IDLE, LANES columns are substituted per cycle in RUN,
// and the result is held in DONE until the consumer takes it.
module ascon_inv_sbox_layer #(
  parameter int LANES = 8
) (
  input  logic                         clock_i,
  input  logic                         resetb_i,
  ascon_inv_sbox_layer_if.slave        bus,
  output logic                         busy_o
);

  localparam int NCHUNK = 64 / LANES;
  // A single chunk needs no counter; keep one bit that simply stays zero.
  localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
          LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
      $error("ascon_inv_sbox_layer: LANES must be 1, 2, 4, 8, 16, 32 or 64");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [319:0]       work_q, work_d;

  logic [319:0]       sub_s;
  logic [63:0]        y0_s, y1_s, y2_s, y3_s, y4_s;
  logic [5:0]         base_s;
  logic [5:0]         col_s;
  logic [4:0]         idx_s;
  logic [4:0]         val_s;

  // Inverse ASCON S-box, column index {x0,x1,x2,x3,x4} (x0 is MSB) -> value.
  function automatic logic [4:0] inv_sbox(input logic [4:0] idx);
    logic [4:0] r;
    case (idx)
      5'h00: r = 5'h14;  5'h01: r = 5'h1A;  5'h02: r = 5'h07;  5'h03: r = 5'h0D;
      5'h04: r = 5'h00;  5'h05: r = 5'h09;  5'h06: r = 5'h0E;  5'h07: r = 5'h12;
      5'h08: r = 5'h0A;  5'h09: r = 5'h06;  5'h0A: r = 5'h1D;  5'h0B: r = 5'h01;
      5'h0C: r = 5'h19;  5'h0D: r = 5'h15;  5'h0E: r = 5'h13;  5'h0F: r = 5'h1E;
      5'h10: r = 5'h18;  5'h11: r = 5'h16;  5'h12: r = 5'h0B;  5'h13: r = 5'h11;
      5'h14: r = 5'h03;  5'h15: r = 5'h05;  5'h16: r = 5'h1C;  5'h17: r = 5'h1F;
      5'h18: r = 5'h17;  5'h19: r = 5'h1B;  5'h1A: r = 5'h04;  5'h1B: r = 5'h08;
      5'h1C: r = 5'h0F;  5'h1D: r = 5'h0C;  5'h1E: r = 5'h10;  5'h1F: r = 5'h02;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Working register with the current chunk of LANES columns substituted.
  always_comb begin
    y0_s   = work_q[319:256];
    y1_s   = work_q[255:192];
    y2_s   = work_q[191:128];
    y3_s   = work_q[127:64];
    y4_s   = work_q[63:0];
    base_s = 6'(int'(cnt_q) * LANES);
    col_s  = 6'd0;
    idx_s  = 5'd0;
    val_s  = 5'd0;
    for (int l = 0; l < LANES; l++) begin
      col_s = base_s + 6'(l);
      idx_s = {work_q[256 + int'(col_s)], work_q[192 + int'(col_s)],
               work_q[128 + int'(col_s)], work_q[64 + int'(col_s)],
               work_q[int'(col_s)]};
      val_s = inv_sbox(idx_s);
      y0_s[col_s] = val_s[4];
      y1_s[col_s] = val_s[3];
      y2_s[col_s] = val_s[2];
      y3_s[col_s] = val_s[1];
      y4_s[col_s] = val_s[0];
    end
    sub_s = {y0_s, y1_s, y2_s, y3_s, y4_s};
  end

  // Next-state logic: accept in IDLE, substitute chunks in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid_i) begin
          work_d  = bus.state_i;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        work_d = sub_s;
        if (cnt_q == CNT_LAST) begin
          // cnt is left at its last value; it restarts on the next accept.
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, chunk counter and working register; reset abandons any transaction.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      work_q  <= 320'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // Outputs are decoded from the state register only; no input-to-output path.
  assign bus.in_ready_o  = (state_q == ST_IDLE);
  assign bus.out_valid_o = (state_q == ST_DONE);
  assign bus.state_o     = work_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule
